// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: mode / field controller for the digital clock.
// Turns four debounced buttons into the mode register, set-field selector,
// inc/dec strobes with hold-to-repeat, a field blink mask, a timed date
// display, and commit/abort strobes for the time/date counter block.
//
// Handshake: there is no valid/ready pair. Every output is a registered
// level or a one-cycle strobe, updated on the clock edge after the button
// press is sampled. Inc_Pulse, Dec_Pulse, Commit and Abort are each high for
// exactly one cycle per event, and Commit and Abort are never high together.
module watch_mode_ctrl #(
  parameter int CLK_HZ       = 32768,
  parameter int NUM_MODES    = 4,
  parameter int NUM_FIELDS   = 3,
  parameter int TIMEOUT_S    = 30,
  parameter int DATE_HOLD_S  = 3,
  parameter int REPEAT_DELAY = 16384,
  parameter int REPEAT_RATE  = 4096,
  parameter int BLINK_DIV    = 16384,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                  clk_32_768K,
  input  logic                  Reset,
  input  logic                  Button0,
  input  logic                  Button1,
  input  logic                  Button2,
  input  logic                  Button3,
  output logic [MW-1:0]         Mode,
  output logic [FW-1:0]         Field,
  output logic                  Inc_Pulse,
  output logic                  Dec_Pulse,
  output logic [NUM_FIELDS-1:0] Blink,
  output logic                  Show_Date,
  output logic                  Commit,
  output logic                  Abort
);

  localparam int TO_CYC   = TIMEOUT_S * CLK_HZ;
  localparam int DATE_CYC = DATE_HOLD_S * CLK_HZ;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;

  // Each counter is wide enough for the largest value it is loaded with.
  localparam int IW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int DW = (DATE_CYC > 0) ? $clog2(DATE_CYC + 1) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IW-1:0] TO_LAST    = IW'(TO_CYC - 1);
  localparam logic [DW-1:0] DATE_LOAD  = DW'(DATE_CYC);
  localparam logic [HW-1:0] DELAY_LOAD = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] RATE_LOAD  = HW'(REPEAT_RATE);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [MW-1:0] MODE_LAST  = MW'(NUM_MODES - 1);
  localparam logic [FW-1:0] FIELD_LAST = FW'(NUM_FIELDS - 1);

  logic [3:0]    btn, btn_q, press;
  logic [MW-1:0] mode, mode_n;
  logic [FW-1:0] field, field_n;
  logic          inc_q, dec_q, commit_q, abort_q;
  logic          commit_n, abort_n;
  logic [1:0]    strobe;
  // hold[0] tracks Button2 (increment), hold[1] tracks Button3 (decrement).
  // A nonzero value means the button is armed for auto-repeat; the count is
  // the number of cycles left until the next repeat strobe.
  logic [HW-1:0] hold [2];
  logic [HW-1:0] hold_n [2];
  logic [IW-1:0] inact, inact_n;
  logic [DW-1:0] date, date_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          phase, phase_n;
  logic          in_set, timeout, view_clr, activity;

  assign btn     = {Button3, Button2, Button1, Button0};
  assign press   = btn & ~btn_q;
  assign in_set  = (mode != '0);
  assign timeout = in_set && (inact == TO_LAST);

  // Next-state logic: timeout beats Button0, which beats Button1, which beats inc/dec.
  always_comb begin
    mode_n    = mode;
    field_n   = field;
    strobe    = 2'b00;
    commit_n  = 1'b0;
    abort_n   = 1'b0;
    hold_n[0] = hold[0];
    hold_n[1] = hold[1];
    date_n    = (date != '0) ? date - DW'(1) : '0;
    inact_n   = inact + IW'(1);
    view_clr  = 1'b0;
    activity  = 1'b0;
    bcnt_n    = bcnt;
    phase_n   = phase;

    if (timeout) begin
      mode_n    = '0;
      field_n   = '0;
      abort_n   = 1'b1;
      view_clr  = 1'b1;
      hold_n[0] = '0;
      hold_n[1] = '0;
    end else if (press[0]) begin
      mode_n    = (mode == MODE_LAST) ? '0 : mode + MW'(1);
      field_n   = '0;
      commit_n  = in_set;
      date_n    = '0;
      view_clr  = 1'b1;
      activity  = 1'b1;
      hold_n[0] = '0;
      hold_n[1] = '0;
    end else if (press[1] && in_set) begin
      field_n   = (field == FIELD_LAST) ? '0 : field + FW'(1);
      view_clr  = 1'b1;
      activity  = 1'b1;
      hold_n[0] = '0;
      hold_n[1] = '0;
    end else if (in_set) begin
      activity = press[2] | press[3];
      if (btn[2] && btn[3]) begin
        // Conflicting inc and dec: neither acts and neither stays armed.
        hold_n[0] = '0;
        hold_n[1] = '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (press[k+2]) begin
            strobe[k] = 1'b1;
            hold_n[k] = DELAY_LOAD;
          end else if (btn[k+2] && (hold[k] != '0)) begin
            if (hold[k] == HW'(1)) begin
              strobe[k] = 1'b1;
              hold_n[k] = RATE_LOAD;
            end else begin
              hold_n[k] = hold[k] - HW'(1);
            end
          end else begin
            hold_n[k] = '0;
          end
        end
      end
      if (strobe != 2'b00) begin
        activity = 1'b1;
        view_clr = 1'b1;
      end
    end else begin
      hold_n[0] = '0;
      hold_n[1] = '0;
      if (press[3]) begin
        date_n = DATE_LOAD;
      end
    end

    if (activity || (mode_n == '0)) begin
      inact_n = '0;
    end

    // Restart the blink cycle on any edit so the touched field shows at once.
    if (view_clr) begin
      bcnt_n  = '0;
      phase_n = 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt_n  = '0;
      phase_n = ~phase;
    end else begin
      bcnt_n  = bcnt + BW'(1);
    end
  end

  // State and strobe registers, all cleared asynchronously by Reset.
  always_ff @(posedge clk_32_768K or posedge Reset) begin
    if (Reset) begin
      btn_q    <= '0;
      mode     <= '0;
      field    <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      commit_q <= 1'b0;
      abort_q  <= 1'b0;
      hold[0]  <= '0;
      hold[1]  <= '0;
      inact    <= '0;
      date     <= '0;
      bcnt     <= '0;
      phase    <= 1'b0;
    end else begin
      btn_q    <= btn;
      mode     <= mode_n;
      field    <= field_n;
      inc_q    <= strobe[0];
      dec_q    <= strobe[1];
      commit_q <= commit_n;
      abort_q  <= abort_n;
      hold[0]  <= hold_n[0];
      hold[1]  <= hold_n[1];
      inact    <= inact_n;
      date     <= date_n;
      bcnt     <= bcnt_n;
      phase    <= phase_n;
    end
  end

  // Blank the selected field during the second half of each blink period.
  always_comb begin
    for (int i = 0; i < NUM_FIELDS; i++) begin
      Blink[i] = in_set && phase && (field == FW'(i));
    end
  end

  assign Mode      = mode;
  assign Field     = field;
  assign Inc_Pulse = inc_q;
  assign Dec_Pulse = dec_q;
  assign Show_Date = (date != '0);
  assign Commit    = commit_q;
  assign Abort     = abort_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl with small timer parameters. A driver applies
// button patterns and pushes the reference model's expected outputs; a
// monitor pops and compares one vector per clock.
module tb_watch_mode_ctrl;

  localparam int CLK_HZ   = 4;
  localparam int NM       = 4;
  localparam int NF       = 3;
  localparam int TO_S     = 4;
  localparam int DH_S     = 3;
  localparam int RD       = 8;
  localparam int RR       = 3;
  localparam int BD       = 4;
  localparam int TO_CYC   = TO_S * CLK_HZ;
  localparam int DATE_CYC = DH_S * CLK_HZ;
  localparam int MW       = 2;
  localparam int FW       = 2;
  localparam int OW       = MW + FW + NF + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic b0, b1, b2, b3;
  logic [MW-1:0] mode_o;
  logic [FW-1:0] field_o;
  logic          inc_o, dec_o, show_o, commit_o, abort_o;
  logic [NF-1:0] blink_o;

  always #5 clk = ~clk;

  watch_mode_ctrl #(
    .CLK_HZ(CLK_HZ), .NUM_MODES(NM), .NUM_FIELDS(NF), .TIMEOUT_S(TO_S),
    .DATE_HOLD_S(DH_S), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_DIV(BD)
  ) dut (
    .clk_32_768K(clk), .Reset(rst),
    .Button0(b0), .Button1(b1), .Button2(b2), .Button3(b3),
    .Mode(mode_o), .Field(field_o), .Inc_Pulse(inc_o), .Dec_Pulse(dec_o),
    .Blink(blink_o), .Show_Date(show_o), .Commit(commit_o), .Abort(abort_o)
  );

  logic [OW-1:0] act_v;
  assign act_v = {mode_o, field_o, inc_o, dec_o, blink_o, show_o, commit_o, abort_o};

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s #%0d: got mode/field/inc/dec/blink/show/commit/abort=%b want %b",
               name, n_vec, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Timestamps instead of counters: edge index of the last activity, of the
  // last blink restart, when each inc/dec button was pressed, and when the
  // date display expires.
  int t = 0;
  int m_mode, m_field;
  logic [3:0] m_prev;
  int st_inc, st_dec, last_act, date_end, blink_clr;

  task automatic model_init();
    m_mode    = 0;
    m_field   = 0;
    m_prev    = 4'b0000;
    st_inc    = -1;
    st_dec    = -1;
    last_act  = t;
    date_end  = 0;
    blink_clr = t - 1;
  endtask

  function automatic bit repeat_due(input int start, input int now);
    int d;
    d = now - start;
    return (d >= RD) && (((d - RD) % RR) == 0);
  endfunction

  task automatic model_step(input logic [3:0] b);
    logic [3:0] p;
    bit inc, dec, com, abt, clr, act, show, phase;
    logic [NF-1:0] bl;
    logic [OW-1:0] ev;
    p = b & ~m_prev;
    inc = 0; dec = 0; com = 0; abt = 0; clr = 0; act = 0;
    if (m_mode != 0 && (t - last_act) == TO_CYC) begin
      m_mode = 0; m_field = 0; abt = 1; clr = 1; st_inc = -1; st_dec = -1;
    end else if (p[0]) begin
      com = (m_mode != 0);
      m_mode = (m_mode + 1) % NM;
      m_field = 0; date_end = 0; clr = 1; act = 1; st_inc = -1; st_dec = -1;
    end else if (p[1] && m_mode != 0) begin
      m_field = (m_field + 1) % NF;
      clr = 1; act = 1; st_inc = -1; st_dec = -1;
    end else if (m_mode != 0) begin
      if (b[2] && b[3]) begin
        st_inc = -1; st_dec = -1;
      end else begin
        if (p[2]) begin inc = 1; st_inc = t; end
        else if (b[2] && st_inc >= 0) inc = repeat_due(st_inc, t);
        else st_inc = -1;
        if (p[3]) begin dec = 1; st_dec = t; end
        else if (b[3] && st_dec >= 0) dec = repeat_due(st_dec, t);
        else st_dec = -1;
      end
      if (p != 4'b0000 || inc || dec) act = 1;
      if (inc || dec) clr = 1;
    end else begin
      st_inc = -1; st_dec = -1;
      if (p[3]) date_end = t + DATE_CYC;
    end
    if (act) last_act = t;
    if (clr) blink_clr = t;
    phase = (((t - blink_clr) / BD) % 2) == 1;
    show  = (t < date_end);
    bl = '0;
    if (m_mode != 0 && phase) bl[m_field] = 1'b1;
    ev = {MW'(m_mode), FW'(m_field), inc, dec, bl, show, com, abt};
    exp_q.push_back(ev);
    m_prev = b;
    t++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] b);
    @(negedge clk);
    #1;
    {b3, b2, b1, b0} = b;
    model_step(b);
  endtask

  task automatic drive_n(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) drive(b);
  endtask

  task automatic tap(input logic [3:0] b);
    drive(b);
    drive(4'b0000);
  endtask

  // Asserts Reset asynchronously in the low clock phase, buttons untouched.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1 check_vec("reset_async", act_v, '0);
    @(posedge clk);
    #1 check_vec("reset_held", act_v, '0);
    #1 rst = 1'b0;
    model_init();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [OW-1:0] ev;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        check_vec("outputs", act_v, ev);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] pat;
    int r, len;
    rst = 1'b1;
    {b3, b2, b1, b0} = 4'b0000;
    repeat (2) @(posedge clk);
    #2 check_vec("reset_state", act_v, '0);
    rst = 1'b0;
    model_init();

    // Mode walk: 1,2,3,0,1 with commits on the three exits from set modes.
    for (int i = 0; i < 5; i++) tap(4'b0001);
    // Field walk and blink on field 2, then an increment restarts the blink.
    for (int i = 0; i < 3; i++) tap(4'b0010);
    tap(4'b0010); tap(4'b0010);
    drive_n(4'b0000, 10);
    tap(4'b0100);
    drive_n(4'b0000, 6);
    // Auto-repeat, then a conflicting Button3 press stops the strobes.
    drive_n(4'b0100, 20);
    drive(4'b0000);
    drive_n(4'b0100, 12);
    drive_n(4'b1100, 6);
    drive_n(4'b0000, 2);
    // Idle into timeout and abort.
    drive_n(4'b0000, 20);
    // Date display with a re-press six cycles later.
    drive(4'b1000);
    drive_n(4'b0000, 5);
    drive(4'b1000);
    drive_n(4'b0000, 16);
    // Timeout pushed back by a Button1 press.
    for (int i = 0; i < 3; i++) tap(4'b0001);
    tap(4'b0010); tap(4'b0010);
    drive_n(4'b0000, 4);
    drive(4'b0010);
    drive_n(4'b0000, 20);
    // Reset while auto-repeat is running; Button2 stays held afterwards.
    tap(4'b0001); tap(4'b0001); tap(4'b0010);
    drive_n(4'b0100, 12);
    mid_reset();
    drive_n(4'b0100, 5);
    drive_n(4'b0000, 2);

    // Random button segments.
    for (int s = 0; s < 160; s++) begin
      r = $urandom_range(0, 7);
      if (r < 5) pat = 4'b0001 << $urandom_range(0, 3);
      else if (r == 5) pat = 4'($urandom_range(0, 15));
      else pat = 4'b0000;
      len = $urandom_range(1, 22);
      drive_n(pat, len);
      drive(4'b0000);
      if (s == 90) mid_reset();
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
Parametrised mode/field controller for the digital clock: it supersedes the fixed two-mode button logic. It takes four debounced buttons and drives the mode register, set-field selector, increment/decrement strobes (with hold-to-repeat), field blink mask, timed date display, and commit/abort strobes. It sits between the debounce modules and the time/date counter block.

Parameters:
CLK_HZ, 32768, clock frequency in Hz; base for all seconds-based timers
NUM_MODES, 4, mode count; mode 0 = normal time display, 1..NUM_MODES-1 = set modes; legal range >=2
NUM_FIELDS, 3, editable fields per set mode (e.g. sec/min/hr); legal range >=1
TIMEOUT_S, 30, set-mode inactivity timeout in seconds
DATE_HOLD_S, 3, seconds the date stays shown after a Button3 press in mode 0
REPEAT_DELAY, 16384, cycles a held inc/dec button must be held before auto-repeat starts
REPEAT_RATE, 4096, cycles between auto-repeat strobes
BLINK_DIV, 16384, cycles per blink half-period

Ports:
clk_32_768K  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Button0  in  1  debounced, high while pressed; mode advance
Button1  in  1  debounced; field advance
Button2  in  1  debounced; increment
Button3  in  1  debounced; decrement in set modes, date display in mode 0
Mode  out  MW=max(1,clog2(NUM_MODES))  current mode
Field  out  FW=max(1,clog2(NUM_FIELDS))  selected field in set modes
Inc_Pulse  out  1  one-cycle increment strobe
Dec_Pulse  out  1  one-cycle decrement strobe
Blink  out  NUM_FIELDS  per-field blank mask (1 = blank digits)
Show_Date  out  1  display date instead of time
Commit  out  1  one-cycle strobe: leaving a set mode via Button0
Abort  out  1  one-cycle strobe: leaving a set mode via timeout

Behaviour:
- Reset (async, high): Mode=0, Field=0, all strobes 0, Blink=0, Show_Date=0, every counter/timer 0, edge-detect registers 0. Outputs stay at these values while Reset is high.
- Edge detect: a registered copy of each button; press = now high and previous low. All reactions are registered: an output changes on the clock edge after the press is sampled (latency 1).
- Priority in one cycle: Button0 press > Button1 press > Button2/Button3. Lower-priority presses in the same cycle are discarded.
- Button0 press: Mode = Mode+1, wrapping NUM_MODES-1 -> 0. Field resets to 0. If the old Mode was not 0, Commit=1 for that cycle. Show_Date is cleared.
- Button1 press, Mode!=0: Field = Field+1, wrapping NUM_FIELDS-1 -> 0. In Mode 0 it is ignored.
- Inc/Dec, Mode!=0:
  - A Button2 press gives Inc_Pulse and a Button3 press gives Dec_Pulse.
  - While the button is still held, a hold counter runs. At REPEAT_DELAY cycles after the press, the first repeat strobe fires. Further strobes follow every REPEAT_RATE cycles until release.
  - Release clears the hold counter.
  - If Button2 and Button3 are high together, neither produces a strobe or a repeat, and both hold counters clear.
- Mode 0:
  - Button2 is ignored.
  - A Button3 press loads the date timer with DATE_HOLD_S*CLK_HZ. Show_Date=1 while the timer is nonzero. A re-press reloads the timer.
- Timeout, Mode!=0:
  - The inactivity counter reloads on any button press or repeat strobe. Otherwise it increments each cycle.
  - When it reaches TIMEOUT_S*CLK_HZ-1: Mode=0, Field=0, Abort=1 for one cycle, no Commit.
  - If a press lands in the timeout cycle, the timeout wins and the press is discarded.
- Blink:
  - The phase counter wraps at BLINK_DIV-1 and toggles phase. Blink = onehot(Field) when Mode!=0 and phase=1, else 0.
  - Any mode change, field change, or Inc/Dec strobe clears the counter and sets phase=0, so the edited field is visible immediately.
- Counters are sized to hold their maximum load value without overflow. Commit and Abort are never high together.

Test Plan:
- Reset mid-operation: CLK_HZ=16, Mode=2, Field=1, Button2 held in repeat; assert Reset for 1 cycle mid-clock -> all outputs 0 immediately; after release no strobe until a fresh press.
- Mode walk: NUM_MODES=4; press Button0 five times -> Mode 1,2,3,0,1; Commit pulses exactly on 1->2, 2->3, 3->0; Field=0 after each press.
- Field and blink: Mode=1, NUM_FIELDS=3, BLINK_DIV=4; Button1 x3 -> Field 1,2,0; at Field=2, Blink toggles 000/100 every 4 cycles; an Inc_Pulse forces Blink=000 for the next 4 cycles.
- Auto-repeat: REPEAT_DELAY=8, REPEAT_RATE=3; hold Button2 20 cycles in Mode 1 -> Inc_Pulse at press+1 and at offsets 8, 11, 14, 17 (5 total); press Button3 while Button2 is held -> strobes stop.
- Date display: CLK_HZ=4, DATE_HOLD_S=3, Mode 0; Button3 press -> Show_Date high 12 cycles; re-press at cycle 6 -> high until cycle 18; Dec_Pulse never fires.
- Timeout: CLK_HZ=4, TIMEOUT_S=2, Mode=3, Field=2, idle -> after 8 cycles Mode=0, Field=0, Abort one cycle, Commit 0; Button1 press at cycle 5 delays timeout to cycle 13.
